// File: rtl/pixel_readout_unpacker.sv
// Unpacks strobed multi-pixel bus words into a ready/valid pixel stream with row/column tracking.
// Define PIXEL_UNPACK_GRAY_EN to decode Gray-coded pixels to binary on the way out.
module pixel_readout_unpacker #(
    parameter int WIDTH                  = 100,
    parameter int HEIGHT                 = 100,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 10,
    parameter int BIT_DEPTH              = 10,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                                        SYSTEM_CLK,
    input  logic                                        SYSTEM_RESET,
    input  logic                                        DATA_OUT_CLK,
    input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_OUT,
    input  logic                                        PIX_READY,
    output logic                                        PIX_VALID,
    output logic [BIT_DEPTH-1:0]                        PIX_DATA,
    output logic [$clog2(WIDTH)-1:0]                    PIX_COL,
    output logic [$clog2(HEIGHT)-1:0]                   PIX_ROW,
    output logic                                        PIX_SOF,
    output logic                                        PIX_EOL,
    output logic                                        PIX_EOF,
    output logic                                        OVERFLOW
);
    localparam int BUS_W = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (OUTPUT_BUS_PIXEL_WIDTH > 1) ? $clog2(OUTPUT_BUS_PIXEL_WIDTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUTPUT_BUS_PIXEL_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic [BIT_DEPTH-1:0] pixel_conv(input logic [BIT_DEPTH-1:0] raw);
`ifdef PIXEL_UNPACK_GRAY_EN
        logic [BIT_DEPTH-1:0] bin;
        bin[BIT_DEPTH-1] = raw[BIT_DEPTH-1];
        for (int i = BIT_DEPTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ raw[i];
        end
        return bin;
`else
        return raw;
`endif
    endfunction

    state_t               state_q;
    logic                 strobe_q;
    logic [BUS_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [BUS_W-1:0]     sr_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 pix_valid_q;
    logic [BIT_DEPTH-1:0] pix_data_q;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic                 overflow_q;

    logic                 capture;
    logic                 fifo_full;
    logic                 xfer;
    logic                 word_done;
    logic                 push;
    logic                 in_shift;
    logic [PTR_W-1:0]     load_ptr;
    logic                 stored;
    logic                 next_avail;
    logic [BUS_W-1:0]     next_word;

    // The word being shifted stays counted in the FIFO until its last pixel leaves,
    // so the next word to load sits one slot behind the head while in SHIFT.
    always_comb begin
        // NOTE: every combinational output is assigned on every path, so no latch is inferred.
        capture    = DATA_OUT_CLK && !strobe_q;
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        xfer       = pix_valid_q && PIX_READY;
        word_done  = xfer && (idx_q == IDX_LAST);
        push       = capture && (!fifo_full || word_done);
        in_shift   = (state_q == SHIFT);
        load_ptr   = rd_ptr_q + PTR_W'(in_shift);
        stored     = (count_q > CNT_W'(in_shift));
        next_avail = stored || push;
        next_word  = stored ? mem_q[load_ptr] : DATA_OUT;
    end

    // NOTE: word storage has no reset; count and pointers alone decide which slots are live.
    always_ff @(posedge SYSTEM_CLK) begin
        if (!SYSTEM_RESET && push) begin
            mem_q[wr_ptr_q] <= DATA_OUT;
        end
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            state_q     <= IDLE;
            strobe_q    <= 1'b1;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            sr_q        <= '0;
            idx_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            strobe_q <= DATA_OUT_CLK;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (word_done) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(word_done);
            if (capture && !push) begin
                overflow_q <= 1'b1;
            end

            if (xfer) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (next_avail) begin
                        pix_data_q  <= pixel_conv(next_word[BIT_DEPTH-1:0]);
                        sr_q        <= next_word >> BIT_DEPTH;
                        idx_q       <= '0;
                        pix_valid_q <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (word_done) begin
                        if (next_avail) begin
                            pix_data_q <= pixel_conv(next_word[BIT_DEPTH-1:0]);
                            sr_q       <= next_word >> BIT_DEPTH;
                            idx_q      <= '0;
                        end else begin
                            pix_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end else if (xfer) begin
                        pix_data_q <= pixel_conv(sr_q[BIT_DEPTH-1:0]);
                        sr_q       <= sr_q >> BIT_DEPTH;
                        idx_q      <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PIX_VALID = pix_valid_q;
    assign PIX_DATA  = pix_data_q;
    assign PIX_COL   = col_q;
    assign PIX_ROW   = row_q;
    assign OVERFLOW  = overflow_q;
    assign PIX_SOF   = pix_valid_q && (col_q == '0) && (row_q == '0);
    assign PIX_EOL   = pix_valid_q && (col_q == COL_LAST);
    assign PIX_EOF   = pix_valid_q && (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: tb/tb_pixel_readout_unpacker.sv
// Bench for pixel_readout_unpacker: directed steps plus random traffic against a pixel-queue
// reference model with independent row/column tracking.
module tb_pixel_readout_unpacker;
    localparam int W  = 100;
    localparam int H  = 100;
    localparam int N  = 10;
    localparam int BD = 10;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            strobe;
    logic [N*BD-1:0] dout;
    logic            ready;
    logic            pix_valid;
    logic [BD-1:0]   pix_data;
    logic [6:0]      pix_col;
    logic [6:0]      pix_row;
    logic            pix_sof;
    logic            pix_eol;
    logic            pix_eof;
    logic            overflow;

    always #5 clk = ~clk;

    pixel_readout_unpacker #(
        .WIDTH(W), .HEIGHT(H), .OUTPUT_BUS_PIXEL_WIDTH(N), .BIT_DEPTH(BD), .FIFO_DEPTH(FD)
    ) dut (
        .SYSTEM_CLK  (clk),
        .SYSTEM_RESET(rst),
        .DATA_OUT_CLK(strobe),
        .DATA_OUT    (dout),
        .PIX_READY   (ready),
        .PIX_VALID   (pix_valid),
        .PIX_DATA    (pix_data),
        .PIX_COL     (pix_col),
        .PIX_ROW     (pix_row),
        .PIX_SOF     (pix_sof),
        .PIX_EOL     (pix_eol),
        .PIX_EOF     (pix_eof),
        .OVERFLOW    (overflow)
    );

    int            checks = 0;
    int            failures = 0;
    logic [BD-1:0] exp_q [$];
    int            exp_col = 0;
    int            exp_row = 0;
    int            xfers = 0;
    int            eol_seen = 0;
    int            eof_seen = 0;
    bit            rand_ready = 1'b0;
    bit            hold_pending = 1'b0;
    logic [BD-1:0] hold_data;
    logic [6:0]    hold_col;
    logic [6:0]    hold_row;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference pixel transform: Gray-to-binary as a prefix XOR of the code word.
    function automatic logic [BD-1:0] model_pix(input logic [BD-1:0] raw);
`ifdef PIXEL_UNPACK_GRAY_EN
        logic [BD-1:0] bin;
        for (int i = 0; i < BD; i++) bin[i] = ^(raw >> i);
        return bin;
`else
        return raw;
`endif
    endfunction

    // Monitor: every transfer is checked against the queue and the bench's own position count.
    always @(negedge clk) begin : monitor
        logic [BD-1:0] e;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", pix_valid, 1);
                check("hold_data", pix_data, hold_data);
                check("hold_col", pix_col, hold_col);
                check("hold_row", pix_row, hold_row);
            end
            if (!pix_valid) check("idle_flags", {pix_sof, pix_eol, pix_eof}, 0);
            if (pix_valid && ready) begin
                check("pixel_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data", pix_data, e);
                    check("col", pix_col, exp_col);
                    check("row", pix_row, exp_row);
                    check("sof", pix_sof, 32'(exp_col == 0 && exp_row == 0));
                    check("eol", pix_eol, 32'(exp_col == W - 1));
                    check("eof", pix_eof, 32'(exp_col == W - 1 && exp_row == H - 1));
                    if (pix_eol) eol_seen++;
                    if (pix_eof) eof_seen++;
                    exp_col = (exp_col + 1) % W;
                    if (exp_col == 0) exp_row = (exp_row + 1) % H;
                    xfers++;
                end
                hold_pending = 1'b0;
            end else if (pix_valid) begin
                hold_pending = 1'b1;
                hold_data = pix_data;
                hold_col = pix_col;
                hold_row = pix_row;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic strobe_word(input logic [N*BD-1:0] w, input bit kept);
        dout = w;
        strobe = 1'b1;
        if (kept) for (int k = 0; k < N; k++) exp_q.push_back(model_pix(w[k*BD +: BD]));
        tick();
        strobe = 1'b0;
        tick();
    endtask

    function automatic logic [N*BD-1:0] rand_word();
        logic [N*BD-1:0] w;
        for (int k = 0; k < N; k++) w[k*BD +: BD] = BD'($urandom);
        return w;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic wait_xfers(input string tag, input int target);
        int n = 0;
        while (xfers < target && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(xfers >= target), 1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_col = 0;
        exp_row = 0;
    endtask

    initial begin
        logic [N*BD-1:0] w;
        int base;
        logic [BD-1:0] hd;
        logic [6:0] hc;

        // Reset with the strobe already high: release must not create a capture.
        rst = 1'b1; strobe = 1'b1; ready = 1'b0; dout = '0;
        @(posedge clk); #1;
        tick(); tick();
        @(negedge clk);
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_col", pix_col, 0);
        check("rst_row", pix_row, 0);
        check("rst_ovf", overflow, 0);
        check("rst_flags", {pix_sof, pix_eol, pix_eof}, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("no_capture_at_release", pix_valid, 0);
        tick();
        strobe = 1'b0;
        tick();

        // Single word, pixel k = k+1, ready held high.
        ready = 1'b1;
        for (int k = 0; k < N; k++) w[k*BD +: BD] = BD'(k + 1);
        dout = w;
        strobe = 1'b1;
        for (int k = 0; k < N; k++) exp_q.push_back(model_pix(BD'(k + 1)));
        @(posedge clk);
        @(negedge clk);
        check("first_valid_latency", pix_valid, 1);
        for (int i = 0; i < N; i++) begin
            check("single_data", pix_data, model_pix(BD'(i + 1)));
            check("single_sof", pix_sof, 32'(i == 0));
            @(negedge clk);
        end
        check("single_done_valid", pix_valid, 0);
        tick();
        strobe = 1'b0;
        tick();

        // Backpressure for 3 cycles after the third pixel.
        base = xfers;
        w = rand_word();
        strobe_word(w, 1'b1);
        wait_xfers("bp_reach_3", base + 3);
        ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) begin
                hd = pix_data;
                hc = pix_col;
                check("bp_held_pixel", pix_data, model_pix(w[3*BD +: BD]));
            end else begin
                check("bp_data_stable", pix_data, hd);
                check("bp_col_stable", pix_col, hc);
            end
            tick();
        end
        ready = 1'b1;
        drain("bp_drained", 50);

        // Random words with random backpressure, spaced so the FIFO cannot fill.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            strobe_word(rand_word(), 1'b1);
            repeat ($urandom_range(28, 38)) tick();
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        drain("rand_drained", 200);

        // Overflow: four words fill the buffer, the fifth is dropped.
        ready = 1'b0;
        @(negedge clk);
        check("ovf_initial", overflow, 0);
        tick();
        for (int i = 0; i < FD; i++) begin
            strobe_word(rand_word(), 1'b1);
            tick();
        end
        @(negedge clk);
        check("ovf_not_yet", overflow, 0);
        tick();
        strobe_word(rand_word(), 1'b0);
        @(negedge clk);
        check("ovf_set", overflow, 1);
        tick();
        ready = 1'b1;
        drain("ovf_drained", 100);
        repeat (5) tick();
        @(negedge clk);
        check("ovf_no_fifth_word", pix_valid, 0);
        check("ovf_sticky", overflow, 1);
        tick();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("ovf_cleared", overflow, 0);
        check("ovf_rst_col", pix_col, 0);
        check("ovf_rst_row", pix_row, 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();

        // Full 100x100 ramp frame.
        eol_seen = 0;
        eof_seen = 0;
        for (int wi = 0; wi < W * H / N; wi++) begin
            for (int k = 0; k < N; k++) w[k*BD +: BD] = BD'(wi * N + k);
            strobe_word(w, 1'b1);
            repeat (8) tick();
        end
        drain("frame_drained", 100);
        @(negedge clk);
        check("frame_eol_count", eol_seen, H);
        check("frame_eof_count", eof_seen, 1);
        check("frame_col_wrap", pix_col, 0);
        check("frame_row_wrap", pix_row, 0);
        check("frame_no_ovf", overflow, 0);
        tick();

        // Reset after pixel 4 of a word, partway into a row.
        base = xfers;
        strobe_word(rand_word(), 1'b1);
        wait_xfers("mid_reach_4", base + 4);
        ready = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_col", pix_col, 0);
        check("mid_rst_row", pix_row, 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        ready = 1'b1;
        w = rand_word();
        dout = w;
        strobe = 1'b1;
        for (int k = 0; k < N; k++) exp_q.push_back(model_pix(w[k*BD +: BD]));
        @(posedge clk);
        @(negedge clk);
        check("restart_valid", pix_valid, 1);
        check("restart_col", pix_col, 0);
        check("restart_row", pix_row, 0);
        check("restart_sof", pix_sof, 1);
        tick();
        strobe = 1'b0;
        drain("restart_drained", 50);

`ifdef PIXEL_UNPACK_GRAY_EN
        w = rand_word();
        w[BD-1:0] = 10'b0000001111;
        dout = w;
        strobe = 1'b1;
        for (int k = 0; k < N; k++) exp_q.push_back(model_pix(w[k*BD +: BD]));
        @(posedge clk);
        @(negedge clk);
        check("gray_pixel0", pix_data, 10);
        tick();
        strobe = 1'b0;
        drain("gray_drained", 50);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
